// File: rtl/laji_int_ctrl.sv
// laji_int_ctrl: N-channel edge-latched, masked, prioritised interrupt controller for the Laji CPU.
// Define LAJI_INT_NESTING_EN to let a higher-priority channel preempt a running handler.
module laji_int_ctrl #(
    parameter int N_CH        = 3,
    parameter int ID_W        = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] int_n,
    input  logic [N_CH-1:0] mask,
    input  logic            ack,
    input  logic            eret,
    output logic            irq,
    output logic [ID_W-1:0] irq_id,
    output logic [N_CH-1:0] pending,
    output logic [N_CH-1:0] in_service
);
    localparam int SW = $clog2(SYNC_STAGES + 2);
    localparam logic [SW-1:0] SETTLED = SW'(SYNC_STAGES + 1);

    logic [N_CH-1:0] sync_q [SYNC_STAGES];
    logic [N_CH-1:0] hist_q, pending_q, pending_d, in_service_q, in_service_d;
    logic [N_CH-1:0] fall, allow, cand, ack_set, eret_clr;
    logic [SW-1:0]   settle_q;
    logic [ID_W-1:0] irq_id_q, irq_id_d;
    logic            irq_q, irq_d, gap_q, ack_fire, run;

    // The chain resets to idle-high; edges are ignored until it has refilled
    // from the live lines, so a line already low at reset release never latches.
    assign fall         = (settle_q == SETTLED) ? (hist_q & ~sync_q[SYNC_STAGES-1]) : '0;
    assign ack_fire     = ack & irq_q;
    assign ack_set      = ack_fire ? (N_CH'(1) << irq_id_q) : '0;
    assign eret_clr     = eret ? (in_service_q & (~in_service_q + N_CH'(1))) : '0;
    assign pending_d    = (pending_q & ~ack_set) | fall;
    assign in_service_d = (in_service_q & ~eret_clr) | ack_set;
    assign cand         = pending_q & ~mask & allow;
    assign irq_d        = ~ack_fire & ~gap_q & (|cand);

    always_comb begin
        allow = '0;
        run   = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
`ifdef LAJI_INT_NESTING_EN
            run = run | in_service_q[i];
`else
            run = |in_service_q;
`endif
            allow[i] = ~run;
        end
    end

    always_comb begin
        irq_id_d = '0;
        for (int i = N_CH - 1; i >= 0; i--)
            if (cand[i]) irq_id_d = ID_W'(i);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '1;
            hist_q       <= '1;
            settle_q     <= '0;
            pending_q    <= '0;
            in_service_q <= '0;
            irq_q        <= 1'b0;
            irq_id_q     <= '0;
            gap_q        <= 1'b0;
        end else begin
            sync_q[0] <= int_n;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
            hist_q       <= sync_q[SYNC_STAGES-1];
            settle_q     <= (settle_q == SETTLED) ? settle_q : settle_q + SW'(1);
            pending_q    <= pending_d;
            in_service_q <= in_service_d;
            irq_q        <= irq_d;
            irq_id_q     <= irq_id_d;
            gap_q        <= ack_fire;
        end
    end

    assign irq        = irq_q;
    assign irq_id     = irq_id_q;
    assign pending    = pending_q;
    assign in_service = in_service_q;
endmodule

// File: tb/tb_laji_int_ctrl.sv
// tb_laji_int_ctrl: directed checks of latching, priority, nesting, masking, collisions and reset.
module tb_laji_int_ctrl;
    logic       clk = 1'b0;
    logic       rst, ack, eret, irq;
    logic [2:0] int_n, mask, pending, in_service;
    logic [1:0] irq_id;
    int         checks = 0;
    int         errors = 0;

    laji_int_ctrl dut (
        .clk(clk), .rst(rst), .int_n(int_n), .mask(mask), .ack(ack), .eret(eret),
        .irq(irq), .irq_id(irq_id), .pending(pending), .in_service(in_service)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
    endtask

    task automatic pulse_eret();
        eret = 1'b1;
        tick(1);
        eret = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; int_n = '1; mask = '0; ack = 1'b0; eret = 1'b0;
        tick(2);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", irq); end
        checks++; if (irq_id !== 2'd0) begin errors++; $display("FAIL reset_irq_id got %0d exp 0", irq_id); end
        checks++; if (pending !== 3'b000) begin errors++; $display("FAIL reset_pending got %b exp 000", pending); end
        checks++; if (in_service !== 3'b000) begin errors++; $display("FAIL reset_in_service got %b exp 000", in_service); end
        rst = 1'b0;
        tick(4);
    endtask

    task automatic test_single();
        int_n = 3'b110;
        tick(2);
        checks++; if (pending !== 3'b000) begin errors++; $display("FAIL single_pending_e2 got %b exp 000", pending); end
        tick(1);
        checks++; if (pending !== 3'b001) begin errors++; $display("FAIL single_pending_e3 got %b exp 001", pending); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL single_irq_e3 got %b exp 0", irq); end
        tick(1);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL single_irq_e4 got %b exp 1", irq); end
        checks++; if (irq_id !== 2'd0) begin errors++; $display("FAIL single_irq_id got %0d exp 0", irq_id); end
        pulse_ack();
        checks++; if (in_service !== 3'b001) begin errors++; $display("FAIL single_in_service got %b exp 001", in_service); end
        checks++; if (pending !== 3'b000) begin errors++; $display("FAIL single_pending_ack got %b exp 000", pending); end
        tick(1);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL single_irq_after_ack got %b exp 0", irq); end
        pulse_eret();
        checks++; if (in_service !== 3'b000) begin errors++; $display("FAIL single_eret got %b exp 000", in_service); end
        tick(3);
        checks++; if (pending !== 3'b000) begin errors++; $display("FAIL single_held_low got %b exp 000", pending); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL single_held_irq got %b exp 0", irq); end
        int_n = '1;
        tick(4);
    endtask

    task automatic test_priority();
        int_n = 3'b001;
        tick(4);
        checks++; if (pending !== 3'b110) begin errors++; $display("FAIL prio_pending got %b exp 110", pending); end
        checks++; if (irq !== 1'b1 || irq_id !== 2'd1) begin errors++; $display("FAIL prio_first got irq=%b id=%0d exp irq=1 id=1", irq, irq_id); end
        pulse_ack();
        checks++; if (in_service !== 3'b010 || pending !== 3'b100) begin errors++; $display("FAIL prio_ack got is=%b pend=%b exp is=010 pend=100", in_service, pending); end
        tick(3);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL prio_ch2_blocked got %b exp 0", irq); end
        pulse_eret();
        checks++; if (in_service !== 3'b000) begin errors++; $display("FAIL prio_eret got %b exp 000", in_service); end
        tick(1);
        checks++; if (irq !== 1'b1 || irq_id !== 2'd2) begin errors++; $display("FAIL prio_second got irq=%b id=%0d exp irq=1 id=2", irq, irq_id); end
        pulse_ack();
        checks++; if (in_service !== 3'b100) begin errors++; $display("FAIL prio_ack2 got %b exp 100", in_service); end
        pulse_eret();
        int_n = '1;
        tick(4);
    endtask

    task automatic test_nesting();
        int_n = 3'b011;
        tick(4);
        checks++; if (irq !== 1'b1 || irq_id !== 2'd2) begin errors++; $display("FAIL nest_ch2 got irq=%b id=%0d exp irq=1 id=2", irq, irq_id); end
        pulse_ack();
        checks++; if (in_service !== 3'b100) begin errors++; $display("FAIL nest_ack2 got %b exp 100", in_service); end
        int_n = 3'b010;
        tick(4);
        checks++; if (pending !== 3'b001) begin errors++; $display("FAIL nest_pending0 got %b exp 001", pending); end
`ifdef LAJI_INT_NESTING_EN
        checks++; if (irq !== 1'b1 || irq_id !== 2'd0) begin errors++; $display("FAIL nest_preempt got irq=%b id=%0d exp irq=1 id=0", irq, irq_id); end
        pulse_ack();
        checks++; if (in_service !== 3'b101) begin errors++; $display("FAIL nest_both got %b exp 101", in_service); end
        pulse_eret();
        checks++; if (in_service !== 3'b100) begin errors++; $display("FAIL nest_eret1 got %b exp 100", in_service); end
        pulse_eret();
        checks++; if (in_service !== 3'b000) begin errors++; $display("FAIL nest_eret2 got %b exp 000", in_service); end
`else
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL nest_wait got %b exp 0", irq); end
        pulse_eret();
        checks++; if (in_service !== 3'b000) begin errors++; $display("FAIL nest_eret got %b exp 000", in_service); end
        tick(1);
        checks++; if (irq !== 1'b1 || irq_id !== 2'd0) begin errors++; $display("FAIL nest_ch0_late got irq=%b id=%0d exp irq=1 id=0", irq, irq_id); end
        pulse_ack();
        checks++; if (in_service !== 3'b001) begin errors++; $display("FAIL nest_ack0 got %b exp 001", in_service); end
        pulse_eret();
`endif
        int_n = '1;
        tick(4);
    endtask

    task automatic test_mask();
        mask = 3'b010;
        int_n = 3'b101;
        tick(4);
        checks++; if (pending !== 3'b010) begin errors++; $display("FAIL mask_pending got %b exp 010", pending); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL mask_irq got %b exp 0", irq); end
        mask = '0;
        tick(1);
        checks++; if (irq !== 1'b1 || irq_id !== 2'd1) begin errors++; $display("FAIL mask_unmask got irq=%b id=%0d exp irq=1 id=1", irq, irq_id); end
        mask = 3'b010;
        tick(1);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL mask_remask got %b exp 0", irq); end
        mask = '0;
        tick(1);
        pulse_ack();
        checks++; if (in_service !== 3'b010 || pending !== 3'b000) begin errors++; $display("FAIL mask_ack got is=%b pend=%b exp is=010 pend=000", in_service, pending); end
        pulse_eret();
        int_n = '1;
        tick(4);
    endtask

    task automatic test_collision();
        int_n = 3'b110;
        tick(4);
        checks++; if (irq !== 1'b1 || irq_id !== 2'd0) begin errors++; $display("FAIL coll_present got irq=%b id=%0d exp irq=1 id=0", irq, irq_id); end
        int_n = 3'b111;
        tick(2);
        int_n = 3'b110;
        tick(2);
        pulse_ack();
        checks++; if (pending !== 3'b001) begin errors++; $display("FAIL coll_pending got %b exp 001", pending); end
        checks++; if (in_service !== 3'b001) begin errors++; $display("FAIL coll_in_service got %b exp 001", in_service); end
        tick(3);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL coll_irq_blocked got %b exp 0", irq); end
        pulse_eret();
        tick(1);
        checks++; if (irq !== 1'b1 || irq_id !== 2'd0) begin errors++; $display("FAIL coll_represent got irq=%b id=%0d exp irq=1 id=0", irq, irq_id); end
        pulse_ack();
        pulse_eret();
        int_n = '1;
        tick(4);
        checks++; if (pending !== 3'b000 || in_service !== 3'b000) begin errors++; $display("FAIL coll_clean got pend=%b is=%b exp 000 000", pending, in_service); end
    endtask

    task automatic test_reset_mid();
        int_n = 3'b011;
        tick(4);
        pulse_ack();
        int_n = 3'b000;
        tick(4);
        checks++; if (pending !== 3'b011 || in_service !== 3'b100) begin errors++; $display("FAIL rmid_setup got pend=%b is=%b exp 011 100", pending, in_service); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (pending !== 3'b000 || in_service !== 3'b000) begin errors++; $display("FAIL rmid_async got pend=%b is=%b exp 000 000", pending, in_service); end
        checks++; if (irq !== 1'b0 || irq_id !== 2'd0) begin errors++; $display("FAIL rmid_async_irq got irq=%b id=%0d exp 0 0", irq, irq_id); end
        tick(2);
        rst = 1'b0;
        tick(8);
        checks++; if (pending !== 3'b000) begin errors++; $display("FAIL rmid_no_spurious got %b exp 000", pending); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rmid_no_irq got %b exp 0", irq); end
        int_n = '1;
        tick(4);
        int_n = 3'b101;
        tick(4);
        checks++; if (irq !== 1'b1 || irq_id !== 2'd1) begin errors++; $display("FAIL rmid_recover got irq=%b id=%0d exp irq=1 id=1", irq, irq_id); end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_nesting();
        test_mask();
        test_collision();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
